// File: rtl/fifo_pkg.sv
// fifo_pkg: helpers shared by the write- and read-side FIFO controllers.
//   pntr_width(awidth) : pointer width for a RAM address width (one wrap bit)
//   bin2gray(b)        : binary to reflected Gray
//   gray2bin(g)        : reflected Gray to binary (XOR prefix from the MSB)
// Functions work on MAX_PW-bit vectors; callers zero-extend their PW-bit
// pointer and truncate the result. Leading zeros are neutral in both
// conversions.
package fifo_pkg;

  localparam int unsigned MAX_PW = 32;

  typedef logic [MAX_PW-1:0] pntr_t;

  function automatic int unsigned pntr_width(input int unsigned awidth);
    return awidth + 1;
  endfunction

  function automatic pntr_t bin2gray(input pntr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic pntr_t gray2bin(input pntr_t g);
    pntr_t b;
    b[MAX_PW-1] = g[MAX_PW-1];
    for (int unsigned i = 1; i < MAX_PW; i++) begin
      b[MAX_PW-1-i] = b[MAX_PW-i] ^ g[MAX_PW-1-i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wr_ctrl_gray_cnt.sv
// gray_cnt: PW-bit pointer held as registered binary and registered Gray.
// Also exposes the next-state values so the owning controller can compute
// registered status flags in the same cycle as the pointer advance.
//   clk_i       : clock
//   aclr_i      : asynchronous active-high clear
//   en_i        : advance pointer by one on this edge
//   bin_o       : registered binary pointer
//   gray_o      : registered Gray pointer
//   bin_next_o  : binary pointer after this edge
//   gray_next_o : Gray pointer after this edge
module gray_cnt
  import fifo_pkg::*;
#(
  parameter int unsigned PW = 4
) (
  input  logic          clk_i,
  input  logic          aclr_i,
  input  logic          en_i,
  output logic [PW-1:0] bin_o,
  output logic [PW-1:0] gray_o,
  output logic [PW-1:0] bin_next_o,
  output logic [PW-1:0] gray_next_o
);

  always_comb begin
    bin_next_o  = en_i ? bin_o + PW'(1) : bin_o;
    gray_next_o = PW'(bin2gray(MAX_PW'(bin_next_o)));
  end

  // Gray is registered from the next-state value rather than decoded from
  // bin_o so the output crossing clock domains comes straight from flops.
  always_ff @(posedge clk_i or posedge aclr_i) begin
    if (aclr_i) begin
      bin_o  <= '0;
      gray_o <= '0;
    end else begin
      bin_o  <= bin_next_o;
      gray_o <= gray_next_o;
    end
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side control of the dual-clock FIFO (write clock domain).
//   clk_i          : write-domain clock
//   aclr_i         : asynchronous active-high reset (shared with read side)
//   wrreq_i        : producer write request
//   rd_pntr_gray_i : Gray read pointer, already synchronized into clk_i
//   wr_en_o        : RAM write enable (combinational, wrreq_i & ~full_o)
//   wr_addr_o      : RAM write address (low bits of registered binary pointer)
//   wr_pntr_gray_o : registered Gray write pointer, to the synchronizer
//   full_o         : registered full flag
//   almost_full_o  : registered wrusedw_o >= ALMOST_FULL_VALUE
//   wrusedw_o      : registered words-in-FIFO as seen from the write side
// Requires AWIDTH >= 2. Writes while full are dropped silently. A stale
// synchronized read pointer only makes the status pessimistic.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter  int unsigned AWIDTH            = 3,
  parameter  int unsigned ALMOST_FULL_VALUE = 2**AWIDTH - 2,
  localparam int unsigned PW                = pntr_width(AWIDTH)
) (
  input  logic              clk_i,
  input  logic              aclr_i,
  input  logic              wrreq_i,
  input  logic [PW-1:0]     rd_pntr_gray_i,
  output logic              wr_en_o,
  output logic [AWIDTH-1:0] wr_addr_o,
  output logic [PW-1:0]     wr_pntr_gray_o,
  output logic              full_o,
  output logic              almost_full_o,
  output logic [PW-1:0]     wrusedw_o
);

  logic          wr_en;
  logic [PW-1:0] wbin;
  logic [PW-1:0] wgray;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] rd_gray_wrapped;
  logic [PW-1:0] usedw_next;
  logic          full_next;
  logic          afull_next;
  logic          full_q;
  logic          afull_q;
  logic [PW-1:0] usedw_q;

  assign wr_en = wrreq_i & ~full_q;

  gray_cnt #(
    .PW (PW)
  ) u_wr_cnt (
    .clk_i       (clk_i),
    .aclr_i      (aclr_i),
    .en_i        (wr_en),
    .bin_o       (wbin),
    .gray_o      (wgray),
    .bin_next_o  (wbin_next),
    .gray_next_o (wgray_next)
  );

  // Full compares in the Gray domain: the write pointer is exactly one
  // depth ahead of the read pointer when the top two Gray bits differ and
  // the remaining bits match.
  always_comb begin
    rd_gray_wrapped = {~rd_pntr_gray_i[PW-1:PW-2], rd_pntr_gray_i[PW-3:0]};
    rbin            = PW'(gray2bin(MAX_PW'(rd_pntr_gray_i)));
    usedw_next      = wbin_next - rbin;
    full_next       = (wgray_next == rd_gray_wrapped);
    afull_next      = (32'(usedw_next) >= ALMOST_FULL_VALUE);
  end

  always_ff @(posedge clk_i or posedge aclr_i) begin
    if (aclr_i) begin
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      usedw_q <= '0;
    end else begin
      full_q  <= full_next;
      afull_q <= afull_next;
      usedw_q <= usedw_next;
    end
  end

  assign wr_en_o        = wr_en;
  assign wr_addr_o      = wbin[AWIDTH-1:0];
  assign wr_pntr_gray_o = wgray;
  assign full_o         = full_q;
  assign almost_full_o  = afull_q;
  assign wrusedw_o      = usedw_q;

endmodule

// File: doc/fifo_wr_ctrl.md
# fifo_wr_ctrl

Write-side control for the dual-clock FIFO, running in the write clock domain. Holds the binary and Gray write pointers, gates RAM writes, and produces the registered full, almost-full and used-words status. Its Gray write pointer feeds the pointer synchronizer toward the read domain. It consumes the read pointer after that synchronizer has brought it into the write domain.

## Interface
- AWIDTH, 3, RAM address width; depth = 2**AWIDTH; pointer width PW = AWIDTH+1
- ALMOST_FULL_VALUE, 2**AWIDTH-2, wrusedw threshold for almost_full_o (1 .. 2**AWIDTH)
- clk_i  in  1  write-domain clock
- aclr_i  in  1  reset, asynchronous, active-high
- wrreq_i  in  1  write request from producer
- rd_pntr_gray_i  in  PW  read pointer (Gray), already synchronized into clk_i domain
- wr_en_o  out  1  RAM write enable
- wr_addr_o  out  AWIDTH  RAM write address
- wr_pntr_gray_o  out  PW  registered Gray write pointer, to synchronizer
- full_o  out  1  FIFO full, registered
- almost_full_o  out  1  wrusedw_o >= ALMOST_FULL_VALUE, registered
- wrusedw_o  out  PW  words in FIFO as seen from write side, registered, 0..2**AWIDTH

## Operation
- Accept: wr_en_o = wrreq_i & ~full_o, combinational. wr_addr_o = wbin[AWIDTH-1:0], driven combinationally from the registered binary pointer.
- Pointer advance: on accept, wbin_next = wbin + 1 modulo 2**PW; otherwise wbin_next = wbin. wgray_next = wbin_next ^ (wbin_next >> 1).
- Registers update every clk_i edge: wbin, wgray (drives wr_pntr_gray_o), full, almost_full, wrusedw.
- Full: full_next = (wgray_next == {~rd_pntr_gray_i[PW-1:PW-2], rd_pntr_gray_i[PW-3:0]}). The top two bits are inverted and the rest are equal.
- Used words: rbin = gray2bin(rd_pntr_gray_i). wrusedw_next = (wbin_next - rbin) mod 2**PW. The result never exceeds 2**AWIDTH.
- Almost full: almost_full_next = (wrusedw_next >= ALMOST_FULL_VALUE).
- Write while full: request ignored. No pointer change and no wr_en_o. No error flag is raised; dropping the write is the producer's responsibility.
- wr_pntr_gray_o changes by exactly one bit per advance, including the wrap from 2**PW-1 to 0.
- Status is pessimistic. A stale synchronized read pointer can only overstate fullness and wrusedw, never understate them.

## Timing
- Reset (aclr_i=1), taking effect immediately: wbin=0, wr_pntr_gray_o=0, full_o=0, almost_full_o=0, wrusedw_o=0, wr_addr_o=0. wr_en_o is 0 only when wrreq_i=0, because it is combinational.
- Reset mid-operation: pointers and flags return to 0 asynchronously. The read side must be reset by the same aclr_i.
- Write latency: an accepted write on edge N is visible in wr_pntr_gray_o, full_o and wrusedw_o after edge N.
- Full asserts on the same edge as the write that fills the last slot. A wrreq_i on the next cycle is rejected.
- Full deasserts one clk_i edge after rd_pntr_gray_i shows the advanced read pointer.
- Simultaneous write and read-pointer advance in one cycle: both are included in the next values, so wrusedw_o is unchanged.
- Throughput: one write per clk_i while not full.

## Structure
- Shared package fifo_pkg holds:
  - function bin2gray(PW-bit);
  - function gray2bin(PW-bit), an XOR prefix from the MSB;
  - pointer-width constant derivation.
- The read-side controller uses the same package functions.
- One natural sub-module: gray_cnt (PW-bit binary+Gray counter with enable and aclr_i). The same block is reused in the read controller.
- The full compare, used-words subtract and almost-full compare stay in fifo_wr_ctrl.

## Test plan
All scenarios use AWIDTH=3, depth 8, PW=4 and ALMOST_FULL_VALUE=6.
- Reset: assert aclr_i between clock edges -> all outputs 0 immediately. Hold rd_pntr_gray_i=0 and wrreq_i=0 -> outputs stay 0.
- Fill: rd_pntr_gray_i=0, wrreq_i=1 for 9 cycles. Required response:
  - wr_addr_o steps 0..7 and wrusedw_o steps 1..8;
  - almost_full_o rises after the 6th write and full_o after the 8th;
  - the 9th request gives wr_en_o=0 and the pointer stays at binary 8 (wr_pntr_gray_o=4'b1100).
- Drain release: from full, set rd_pntr_gray_i=4'b0001 (read pointer 1). One edge later, full_o=0 and wrusedw_o=7; almost_full_o stays 1.
- Simultaneous: wrusedw_o=4, one write accepted while rd_pntr_gray_i advances by 1 in the same cycle -> wrusedw_o stays 4 and the address increments.
- Wrap: 40 writes interleaved with read-pointer advances. Check that:
  - wr_pntr_gray_o changes exactly one bit per write, including the 15->0 wrap;
  - wrusedw_o matches a scoreboard model every cycle.
- Mid-operation reset: aclr_i pulse while full -> full_o=0, wrusedw_o=0, wr_addr_o=0. The next write goes to address 0.
